// File: rtl/compare_unit_pkg.sv
// Shared definitions for the CP0 Compare unit: strobe levels, FSM state
// encoding and the Compare reset value.
package compare_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] COMPARE_RST = '0;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FIRED    = 2'd2
  } cmp_state_e;

  function automatic logic is_match(input logic [DATA_W-1:0] count,
                                    input logic [DATA_W-1:0] cmp);
    return (count == cmp);
  endfunction

endpackage

// File: rtl/compare_unit.sv
// CP0 Compare register with timer-interrupt FSM (DISARMED/ARMED/FIRED).
// Match is against the registered Compare value; a write always wins over a match.
module compare_unit
  import compare_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] count_value,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              im_timer,
  output logic [DATA_W-1:0] read_data,
  output logic              timer_pending,
  output logic              timer_int
);

  cmp_state_e        state_q, state_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              pending_q, pending_d;
  logic              match;

  assign match = is_match(count_value, compare_q);

  always_comb begin
    state_d   = state_q;
    compare_d = compare_q;
    if (we == ENABLE) begin
      compare_d = wdata;
    end
    unique case (state_q)
      ST_DISARMED: begin
        if (we == ENABLE) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (we == DISABLE && match) state_d = ST_FIRED;
      end
      ST_FIRED: begin
        if (we == ENABLE) state_d = ST_ARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  // Pending is registered from the next state so it tracks FIRED exactly.
  always_comb begin
    pending_d   = (state_d == ST_FIRED);
    read_data_d = (re == ENABLE) ? compare_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst == ENABLE) begin
      state_q     <= ST_DISARMED;
      compare_q   <= COMPARE_RST;
      read_data_q <= '0;
      pending_q   <= DISABLE;
    end else begin
      state_q     <= state_d;
      compare_q   <= compare_d;
      read_data_q <= read_data_d;
      pending_q   <= pending_d;
    end
  end

  assign read_data     = read_data_q;
  assign timer_pending = pending_q;
  assign timer_int     = pending_q & im_timer;

endmodule

// File: tb/tb_compare_unit.sv
// Directed, table-driven bench for compare_unit with a few hand sequences.
module tb_compare_unit;

  logic        clk;
  logic        rst;
  logic [31:0] count_value;
  logic        we;
  logic [31:0] wdata;
  logic        re;
  logic        im_timer;
  logic [31:0] read_data;
  logic        timer_pending;
  logic        timer_int;

  int errors = 0;
  int checks = 0;

  compare_unit dut (
    .clk           (clk),
    .rst           (rst),
    .count_value   (count_value),
    .we            (we),
    .wdata         (wdata),
    .re            (re),
    .im_timer      (im_timer),
    .read_data     (read_data),
    .timer_pending (timer_pending),
    .timer_int     (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] count;
    logic        im;
    logic        exp_pend;
    logic        exp_int;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [31:0] wd,
                     input logic rd_en, input logic [31:0] cnt, input logic im,
                     input logic ep, input logic ei, input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.we = w; v.wdata = wd; v.re = rd_en; v.count = cnt; v.im = im;
    v.exp_pend = ep; v.exp_int = ei; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wdata = '0; re = 1'b0; count_value = '0; im_timer = 1'b0;

    // Reset, overriding a simultaneous write/read; then sweep with no write.
    add(1, 1, 32'd7, 1, 32'd0, 0, 0, 0, 32'h0);
    add(1, 0, 32'd0, 0, 32'd0, 0, 0, 0, 32'h0);
    add(0, 0, 32'd0, 1, 32'd0, 0, 0, 0, 32'h0);
    for (int c = 0; c <= 20; c++) add(0, 0, 32'd0, 0, 32'(c), 0, 0, 0, 32'h0);

    // Compare = 10, count 0..12; unmask at 12.
    add(0, 1, 32'd10, 0, 32'd0, 0, 0, 0, 32'h0);
    for (int c = 0; c <= 12; c++)
      add(0, 0, 32'd0, 0, 32'(c), (c == 12), (c >= 10), (c == 12), 32'h0);
    add(0, 0, 32'd0, 1, 32'd12, 1, 1, 1, 32'd10);

    // Rewrite while FIRED, fire again at 100.
    add(0, 1, 32'd100, 0, 32'd13, 0, 0, 0, 32'h0);
    add(0, 0, 32'd0,   0, 32'd99, 0, 0, 0, 32'h0);
    add(0, 0, 32'd0,   0, 32'd100, 0, 1, 0, 32'h0);
    add(0, 0, 32'd0,   0, 32'd101, 1, 1, 1, 32'h0);

    // Write wins over a same-cycle match.
    add(0, 1, 32'd5,  0, 32'd102, 0, 0, 0, 32'h0);
    add(0, 1, 32'd50, 0, 32'd5,   0, 0, 0, 32'h0);
    add(0, 0, 32'd0,  0, 32'd5,   0, 0, 0, 32'h0);
    add(0, 0, 32'd0,  0, 32'd50,  0, 1, 0, 32'h0);

    // Wrap-around and read-during-write.
    add(0, 1, 32'hFFFF_FFFF, 0, 32'd51,        0, 0, 0, 32'h0);
    add(0, 0, 32'd0,         0, 32'hFFFF_FFFE, 0, 0, 0, 32'h0);
    add(0, 0, 32'd0,         0, 32'hFFFF_FFFF, 0, 1, 0, 32'h0);
    add(0, 0, 32'd0,         0, 32'h0,         0, 1, 0, 32'h0);
    add(0, 1, 32'h1,         1, 32'h1,         0, 0, 0, 32'hFFFF_FFFF);
    // Count stalled at the newly written value fires one cycle later.
    add(0, 0, 32'd0,         0, 32'h1,         0, 1, 0, 32'h0);
    add(0, 0, 32'd0,         1, 32'h2,         0, 1, 0, 32'h1);

    // Reset while FIRED, overriding we/re; no fire until a new write.
    add(1, 1, 32'd9, 1, 32'd2, 1, 0, 0, 32'h0);
    add(0, 0, 32'd0, 1, 32'd0, 1, 0, 0, 32'h0);
    add(0, 0, 32'd0, 0, 32'd1, 1, 0, 0, 32'h0);
    add(0, 0, 32'd0, 0, 32'd9, 0, 0, 0, 32'h0);
    add(0, 1, 32'd3, 0, 32'd2, 0, 0, 0, 32'h0);
    add(0, 0, 32'd0, 0, 32'd3, 0, 1, 0, 32'h0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; we = vecs[i].we; wdata = vecs[i].wdata;
      re = vecs[i].re; count_value = vecs[i].count; im_timer = vecs[i].im;
      @(posedge clk);
      #1;
      chk("timer_pending", i, 32'(timer_pending), 32'(vecs[i].exp_pend));
      chk("timer_int",     i, 32'(timer_int),     32'(vecs[i].exp_int));
      chk("read_data",     i, read_data,          vecs[i].exp_rd);
    end

    // Mask is combinational and never disturbs pending.
    rst = 1'b0; we = 1'b0; re = 1'b0; count_value = 32'd4;
    im_timer = 1'b0;
    #1;
    chk("mask_off_int",  -1, 32'(timer_int),     32'd0);
    chk("mask_off_pend", -1, 32'(timer_pending), 32'd1);
    im_timer = 1'b1;
    #1;
    chk("mask_on_int",   -1, 32'(timer_int),     32'd1);
    @(posedge clk);
    #1;
    im_timer = 1'b0;
    #1;
    chk("mask_hold_pend", -1, 32'(timer_pending), 32'd1);
    chk("mask_hold_int",  -1, 32'(timer_int),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compare_unit.md
COMPARE_UNIT -- requirements
Module: compare_unit

Interface
REQ-001 The block SHALL be single-clock with synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high (`ENABLE).
REQ-004 count_value  input  32  live Count register value from the count unit.
REQ-005 we  input  1  write strobe for Compare (MTC0 Compare).
REQ-006 wdata  input  32  Compare write data, sampled when we=`ENABLE.
REQ-007 re  input  1  read strobe for Compare (MFC0 Compare).
REQ-008 im_timer  input  1  interrupt mask bit from Status.IM7; 1 = timer interrupt enabled.
REQ-009 read_data  output  32  registered Compare read data.
REQ-010 timer_pending  output  1  Cause.TI / IP7 pending flag.
REQ-011 timer_int  output  1  masked interrupt request, timer_pending AND im_timer (combinational).

Function
REQ-012 The block SHALL hold a 32-bit compare register, reset value 32'h0000_0000.
REQ-013 The block SHALL implement a 3-state FSM: DISARMED, ARMED, FIRED; reset state DISARMED.
REQ-014 In DISARMED: no match detection; we -> ARMED next cycle, compare <= wdata.
REQ-015 In ARMED: count_value == compare with we low -> FIRED next cycle, timer_pending = 1 that cycle (latency one clock from match).
REQ-016 In ARMED with we high: compare <= wdata, stay ARMED; a same-cycle match SHALL be ignored (write wins).
REQ-017 In FIRED: timer_pending held at 1 regardless of count_value; we -> compare <= wdata, ARMED, timer_pending = 0 next cycle.
REQ-018 Match SHALL compare count_value against the stored (registered) compare, never against wdata.
REQ-019 If a newly written compare equals a count_value still present the following cycle (count stalled), the block SHALL fire one cycle later.
REQ-020 Match SHALL be pure 32-bit equality; Count wrap-around (FFFF_FFFF -> 0) needs no special handling.
REQ-021 re high in cycle N SHALL place compare in read_data at N+1; with re low read_data SHALL be 32'h0.
REQ-022 re and we in the same cycle SHALL return the pre-write compare value.
REQ-023 im_timer SHALL affect only timer_int, never FSM state or timer_pending.
REQ-024 timer_pending SHALL be a registered output, high exactly while the FSM is in FIRED.

Reset
REQ-025 rst high at any edge SHALL force compare = 0, state = DISARMED, timer_pending = 0, read_data = 0, overriding we/re in the same cycle.
REQ-026 Reset in FIRED SHALL drop timer_pending the cycle after the reset edge; no interrupt SHALL fire until a new Compare write.

Structure
REQ-027 `ENABLE/`DISABLE, FSM state encodings and the compare reset value SHALL live in the shared head.v include.
REQ-028 The block SHALL be a single module with no sub-modules; the count unit is instantiated alongside it at CP0 top level, not inside it.

Verification
REQ-029 Reset then count_value sweeps 0..20 without write -> timer_pending stays 0 (DISARMED).
REQ-030 Write wdata=32'd10, count steps 0..12 -> timer_pending rises the cycle after count_value=10 and stays high at 11,12; im_timer=0 keeps timer_int=0, im_timer=1 gives timer_int=1.
REQ-031 In FIRED write wdata=32'd100 -> timer_pending=0 next cycle; count reaching 100 fires again one cycle later.
REQ-032 ARMED, compare=32'd5, we with wdata=32'd50 in the cycle count_value=5 -> no fire; fire follows count_value=50.
REQ-033 compare=32'hFFFF_FFFF, count wraps FFFF_FFFE->FFFF_FFFF->0 -> fire once after FFFF_FFFF; re with we=wdata 32'h1 same cycle -> read_data=32'hFFFF_FFFF.
REQ-034 Assert rst while FIRED -> next cycle timer_pending=0, read_data=0, and no fire on later matches until compare is written.
